// File: rtl/z_group1_div.sv
// Unsigned restoring divider: a PSIZE-bit dividend divided by a BSIZE-bit divisor.
// One quotient bit per ce-enabled cycle, MSB first. Divide-by-zero and quotient overflow bypass the iteration.
module z_group1_div #(
    parameter int ASIZE = 33,
    parameter int BSIZE = 47,
    localparam int PSIZE = ASIZE + BSIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             start,
    input  logic [PSIZE-1:0] dividend,
    input  logic [BSIZE-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [ASIZE-1:0] q,
    output logic [BSIZE-1:0] r,
    output logic             dz,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    // Handshake: start is sampled only while idle with ce=1. busy covers accept through the
    // done cycle, and done stays high until a ce-enabled edge leaves DONE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             err;
    logic             last;
    logic [5:0]       cnt;
    logic [BSIZE:0]   rem;
    logic [ASIZE-1:0] qsh;
    logic [BSIZE-1:0] dvs;
    logic [BSIZE:0]   trial;
    logic [BSIZE+1:0] diff;
    logic             qbit;
    logic [BSIZE:0]   rem_nx;

    // A high part >= divisor means the quotient cannot fit in ASIZE bits.
    assign err  = (divisor == '0) || (dividend[PSIZE-1:ASIZE] >= divisor);
    assign last = (cnt == 6'd0);

    // A set MSB shifted out of the remainder forces a subtract.
    assign trial  = {rem[BSIZE-1:0], qsh[ASIZE-1]};
    assign diff   = {1'b0, trial} - {2'b00, dvs};
    assign qbit   = rem[BSIZE] | ~diff[BSIZE+1];
    assign rem_nx = qbit ? diff[BSIZE:0] : trial;

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = err ? DONE : CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            qsh <= '0;
            dvs <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
            ovf <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= 6'(ASIZE - 1);
                        rem <= {1'b0, dividend[PSIZE-1:ASIZE]};
                        qsh <= dividend[ASIZE-1:0];
                        dvs <= divisor;
                        if (err) begin
                            q   <= '1;
                            r   <= '0;
                            dz  <= (divisor == '0);
                            ovf <= (divisor != '0);
                        end else begin
                            q   <= '0;
                            r   <= '0;
                            dz  <= 1'b0;
                            ovf <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    qsh <= {qsh[ASIZE-2:0], qbit};
                    if (last) begin
                        q <= {qsh[ASIZE-2:0], qbit};
                        r <= rem_nx[BSIZE-1:0];
                    end else begin
                        cnt <= cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_z_group1_div.sv
// Directed bench for z_group1_div: an arithmetic reference model feeds a result queue,
// one compare process checks every done pulse, and literal expectations pin the model.
module tb_z_group1_div;

    localparam int ASIZE = 33;
    localparam int BSIZE = 47;
    localparam int PSIZE = ASIZE + BSIZE;
    localparam int W     = 2 + ASIZE + BSIZE;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic             start;
    logic [PSIZE-1:0] dividend;
    logic [BSIZE-1:0] divisor;
    logic             busy;
    logic             done;
    logic [ASIZE-1:0] q;
    logic [BSIZE-1:0] r;
    logic             dz;
    logic             ovf;
    logic [1:0]       fsm_state;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    bit done_seen = 1'b0;

    z_group1_div #(.ASIZE(ASIZE), .BSIZE(BSIZE)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .q(q), .r(r), .dz(dz), .ovf(ovf),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Result packing: {dz, ovf, q, r}.
    function automatic logic [W-1:0] model(input logic [PSIZE-1:0] dvd, input logic [BSIZE-1:0] dv);
        logic [PSIZE-1:0] qf;
        logic [PSIZE-1:0] rf;
        if (dv == '0) return {1'b1, 1'b0, {ASIZE{1'b1}}, {BSIZE{1'b0}}};
        qf = dvd / {{ASIZE{1'b0}}, dv};
        rf = dvd % {{ASIZE{1'b0}}, dv};
        if (qf > {{BSIZE{1'b0}}, {ASIZE{1'b1}}}) return {1'b0, 1'b1, {ASIZE{1'b1}}, {BSIZE{1'b0}}};
        return {2'b00, qf[ASIZE-1:0], rf[BSIZE-1:0]};
    endfunction

    // compare process
    always @(negedge clk) begin
        if (rst) begin
            done_seen = 1'b0;
        end else if (done && !done_seen) begin
            done_seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 96'(done), 96'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sb_q",   96'(q),    96'(e[ASIZE+BSIZE-1:BSIZE]));
                chk("sb_r",   96'(r),    96'(e[BSIZE-1:0]));
                chk("sb_dz",  96'(dz),   96'(e[W-1]));
                chk("sb_ovf", 96'(ovf),  96'(e[W-2]));
                chk("sb_busy_with_done", 96'(busy), 96'(1));
            end
        end else if (!done) begin
            done_seen = 1'b0;
        end
    end

    // driver: one request, optional ce stall window during CALC, optional start mid-CALC,
    // optional ce-low hold of the done cycle, optional start during the done cycle
    task automatic run_op(input logic [PSIZE-1:0] dvd, input logic [BSIZE-1:0] dv,
                          input int stall_at, input int stall_len, input bit start_mid,
                          input int done_hold, input bit start_in_done);
        logic [W-1:0] m;
        int total;
        int exp_lat;
        m = model(dvd, dv);
        exp_lat = (m[W-1] | m[W-2]) ? 0 : ASIZE + stall_len;
        exp_q.push_back(m);
        @(posedge clk); #1;
        dividend = dvd;
        divisor  = dv;
        start    = 1'b1;
        ce       = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = 80'({$urandom, $urandom, $urandom});
        divisor  = 47'({$urandom, $urandom});
        total = 0;
        while (total < 200) begin
            @(negedge clk);
            if (done) break;
            chk("busy_calc", 96'(busy), 96'(1));
            ce    = !(total >= stall_at && total < stall_at + stall_len);
            start = start_mid && (total == 3);
            @(posedge clk); #1;
            total++;
        end
        ce    = 1'b1;
        start = 1'b0;
        chk("latency", 96'(total), 96'(exp_lat));
        if (done_hold > 0) begin
            ce = 1'b0;
            repeat (done_hold) begin
                @(posedge clk); #1;
                chk("done_held_ce_low", 96'(done), 96'(1));
            end
            ce = 1'b1;
        end
        start = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_one_cycle", 96'(done), 96'(0));
        if (start_in_done) chk("start_in_done_ignored", 96'(busy), 96'(0));
    endtask

    task automatic lit(input string name, input logic [ASIZE-1:0] eq, input logic [BSIZE-1:0] er,
                       input logic edz, input logic eovf);
        chk({name, "_q"},   96'(q),   96'(eq));
        chk({name, "_r"},   96'(r),   96'(er));
        chk({name, "_dz"},  96'(dz),  96'(edz));
        chk({name, "_ovf"}, 96'(ovf), 96'(eovf));
    endtask

    initial begin
        logic [ASIZE-1:0] a;
        logic [BSIZE-1:0] b;
        logic [BSIZE-1:0] bmax;
        logic [PSIZE-1:0] rt;
        int n_done;

        rst = 1'b1; ce = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_q",    96'(q),    96'(0));
        chk("rst_r",    96'(r),    96'(0));
        chk("rst_flags", 96'({dz, ovf}), 96'(0));
        rst = 1'b0;

        run_op(80'd1000, 47'd7, 1000, 0, 1'b0, 0, 1'b0);
        lit("basic", 33'd142, 47'd6, 1'b0, 1'b0);

        run_op(80'h5, 47'd0, 1000, 0, 1'b0, 3, 1'b1);
        lit("dz", 33'h1_FFFF_FFFF, 47'd0, 1'b1, 1'b0);

        run_op(80'd3 << 33, 47'd3, 1000, 0, 1'b0, 0, 1'b0);
        lit("ovf", 33'h1_FFFF_FFFF, 47'd0, 1'b0, 1'b1);

        run_op((80'd3 << 33) - 80'd1, 47'd3, 1000, 0, 1'b0, 0, 1'b1);
        lit("ovf_edge", 33'h1_FFFF_FFFF, 47'd2, 1'b0, 1'b0);

        a  = 33'h1_2345_6789;
        b  = 47'h0ABC_DEF0_1234;
        rt = 80'(a) * 80'(b) + 80'(b) - 80'd1;
        run_op(rt, b, 1000, 0, 1'b0, 2, 1'b0);
        lit("roundtrip", a, b - 47'd1, 1'b0, 1'b0);

        run_op(80'd1000, 47'd7, 10, 5, 1'b1, 0, 1'b0);
        lit("stall", 33'd142, 47'd6, 1'b0, 1'b0);

        run_op(80'd0, 47'd5, 1000, 0, 1'b0, 0, 1'b0);
        lit("zero_num", 33'd0, 47'd0, 1'b0, 1'b0);

        run_op(80'h1_FFFF_FFFF, 47'd1, 1000, 0, 1'b0, 0, 1'b0);
        lit("div_one", 33'h1_FFFF_FFFF, 47'd0, 1'b0, 1'b0);

        bmax = '1;
        run_op({bmax, 33'd0} - 80'd1, bmax, 1000, 0, 1'b0, 0, 1'b0);
        lit("max_div", 33'h1_FFFF_FFFF, bmax - 47'd1, 1'b0, 1'b0);

        run_op('1, bmax, 1000, 0, 1'b0, 0, 1'b0);
        lit("max_ovf", 33'h1_FFFF_FFFF, 47'd0, 1'b0, 1'b1);

        // abort mid-CALC: no expectation is queued, so any done pulse is flagged
        @(posedge clk); #1;
        dividend = 80'd1000; divisor = 47'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 96'(busy), 96'(0));
        chk("abort_done", 96'(done), 96'(0));
        chk("abort_qr",   96'({q, r}), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", 96'(n_done), 96'(0));

        run_op(80'd1000, 47'd7, 1000, 0, 1'b0, 0, 1'b0);
        lit("after_abort", 33'd142, 47'd6, 1'b0, 1'b0);

        // async reset clears held results without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("rst_held_q", 96'(q), 96'(0));
        chk("rst_held_r", 96'(r), 96'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        chk("queue_drained", 96'(exp_q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
